// File: rtl/lfsr_burst_if.sv
// Handshake bundle between the control logic, the LFSR_22 generator and
// the burst sequencer.
interface lfsr_burst_if #(
    parameter int LFSR_W = 22,
    parameter int CNT_W  = 16,
    parameter int DEC_W  = 4
);
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  burst_len;
    logic [DEC_W-1:0]  decim;
    logic              lfsr_load;
    logic [LFSR_W-1:0] lfsr_q;
    logic [1:0]        sym_out;
    logic              sym_valid;
    logic              busy;
    logic              done;
    logic              wrap;

    // Environment side: control requests and the LFSR state
    modport master (
        output start, abort, burst_len, decim, lfsr_q,
        input  lfsr_load, sym_out, sym_valid, busy, done, wrap
    );

    // Sequencer side
    modport slave (
        input  start, abort, burst_len, decim, lfsr_q,
        output lfsr_load, sym_out, sym_valid, busy, done, wrap
    );
endinterface

// File: rtl/lfsr_burst_ctrl.sv
// Burst sequencer for the LFSR_22 PRBS source: seeds the LFSR, decimates its
// state into 2-bit symbols and reports completion and seed recurrence.
module lfsr_burst_ctrl #(
    parameter int LFSR_W = 22,
    parameter int CNT_W  = 16,
    parameter int DEC_W  = 4
) (
    input  logic         clk,
    input  logic         reset,
    lfsr_burst_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e             state_q,       state_d;
    logic [DEC_W-1:0]   decim_q,       decim_d;
    logic [DEC_W-1:0]   phase_q,       phase_d;
    logic [CNT_W-1:0]   remaining_q,   remaining_d;
    logic [LFSR_W-1:0]  seed_q,        seed_d;
    logic               first_q,       first_d;
    logic               lfsr_load_q,   lfsr_load_d;
    logic               busy_q,        busy_d;
    logic               sym_valid_q,   sym_valid_d;
    logic               done_q,        done_d;
    logic               wrap_q,        wrap_d;
    logic [1:0]         sym_out_q,     sym_out_d;

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        decim_d     = decim_q;
        phase_d     = phase_q;
        remaining_d = remaining_q;
        seed_d      = seed_q;
        first_d     = first_q;
        lfsr_load_d = 1'b0;
        busy_d      = 1'b0;
        sym_valid_d = 1'b0;
        done_d      = 1'b0;
        wrap_d      = wrap_q;
        sym_out_d   = sym_out_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    wrap_d = 1'b0;
                    if (bus.burst_len != '0) begin
                        state_d     = ST_LOAD;
                        decim_d     = bus.decim;
                        remaining_d = bus.burst_len;
                        lfsr_load_d = 1'b1;
                        busy_d      = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_LOAD: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    phase_d = '0;
                    first_d = 1'b1;
                end
            end

            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    busy_d  = 1'b1;
                    first_d = 1'b0;
                    // The LFSR shows the seed only on the first RUN cycle
                    if (first_q) begin
                        seed_d = bus.lfsr_q;
                    end else if (bus.lfsr_q == seed_q) begin
                        wrap_d = 1'b1;
                    end else begin
                        wrap_d = wrap_q;
                    end

                    if (phase_q == decim_q) begin
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + DEC_W'(1);
                    end

                    if (phase_q == '0) begin
                        sym_out_d   = bus.lfsr_q[1:0];
                        sym_valid_d = 1'b1;
                        remaining_d = remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            decim_q     <= '0;
            phase_q     <= '0;
            remaining_q <= '0;
            seed_q      <= '0;
            first_q     <= 1'b0;
            lfsr_load_q <= 1'b0;
            busy_q      <= 1'b0;
            sym_valid_q <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
            sym_out_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            decim_q     <= decim_d;
            phase_q     <= phase_d;
            remaining_q <= remaining_d;
            seed_q      <= seed_d;
            first_q     <= first_d;
            lfsr_load_q <= lfsr_load_d;
            busy_q      <= busy_d;
            sym_valid_q <= sym_valid_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
            sym_out_q   <= sym_out_d;
        end
    end

    assign bus.lfsr_load = lfsr_load_q;
    assign bus.busy      = busy_q;
    assign bus.sym_valid = sym_valid_q;
    assign bus.done      = done_q;
    assign bus.wrap      = wrap_q;
    assign bus.sym_out   = sym_out_q;

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Randomized bench for lfsr_burst_ctrl with a mock LFSR_22 and a cycle-table
// reference model derived from the burst timing rules.
module tb_lfsr_burst_ctrl;
    localparam int LFSR_W = 22;
    localparam int CNT_W  = 16;
    localparam int DEC_W  = 4;
    localparam int MAXC   = 256;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lfsr_burst_if #(.LFSR_W(LFSR_W), .CNT_W(CNT_W), .DEC_W(DEC_W)) bus ();

    lfsr_burst_ctrl #(.LFSR_W(LFSR_W), .CNT_W(CNT_W), .DEC_W(DEC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Mock LFSR: mode 0 is a maximal 22-bit LFSR, mode 1 cycles with period 5
    logic [LFSR_W-1:0] mock_seed;
    int                mock_mode;
    always @(posedge clk) begin
        if (reset)
            bus.lfsr_q <= 22'h1;
        else if (bus.lfsr_load)
            bus.lfsr_q <= mock_seed;
        else if (mock_mode == 1)
            bus.lfsr_q <= (bus.lfsr_q == mock_seed + 22'd4) ? mock_seed : bus.lfsr_q + 22'd1;
        else
            bus.lfsr_q <= {bus.lfsr_q[20:0], bus.lfsr_q[21] ^ bus.lfsr_q[20]};
    end

    // obs/exp vector: {lfsr_load, busy, sym_valid, done, wrap, sym_out[1:0]}
    logic [6:0]        obs   [0:MAXC-1];
    logic [6:0]        exp_v [0:MAXC-1];
    logic [LFSR_W-1:0] trace [0:MAXC-1];
    int   n_cyc;
    int   pass_cnt  = 0;
    int   check_cnt = 0;
    logic       wrap_prev;
    logic [1:0] sym_prev;

    function automatic logic [6:0] out_vec();
        return {bus.lfsr_load, bus.busy, bus.sym_valid, bus.done, bus.wrap, bus.sym_out};
    endfunction

    // Drive one burst starting in cycle 0; record outputs and LFSR per cycle
    task automatic drive_burst(input int n, input int d, input int abort_at,
                               input int tail, input bit noise);
        int last_s, done_c, stop;
        last_s = 2 + (n - 1) * (d + 1);
        done_c = (n == 0) ? 1 : last_s + 1;
        stop   = (abort_at > 0) ? abort_at : done_c;
        n_cyc  = stop + 1 + tail;
        for (int c = 0; c < n_cyc; c++) begin
            if (c == 0) begin
                bus.start     = 1'b1;
                bus.burst_len = CNT_W'(n);
                bus.decim     = DEC_W'(d);
            end else begin
                bus.start = (noise && c <= stop) ? 1'($urandom_range(0, 1)) : 1'b0;
                if (noise) begin
                    bus.burst_len = CNT_W'($urandom);
                    bus.decim     = DEC_W'($urandom);
                end
            end
            bus.abort = (abort_at > 0 && c == abort_at);
            @(negedge clk);
            obs[c]   = out_vec();
            trace[c] = bus.lfsr_q;
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    // Expected outputs from the burst timing rules and the recorded LFSR trace
    task automatic model_burst(input int n, input int d, input int abort_at);
        int   last_s, a;
        bit   ld, by, vl, dn;
        logic w;
        logic [1:0] s;
        last_s = 2 + (n - 1) * (d + 1);
        a = (abort_at > 0) ? abort_at : 32'h3fff_ffff;
        w = wrap_prev;
        s = sym_prev;
        for (int c = 0; c < n_cyc; c++) begin
            ld = (n > 0) && (c == 1);
            by = (n > 0) && (c >= 1) && (c <= last_s) && (c <= a);
            vl = (n > 0) && (c >= 3) && (c <= a) && (((c - 3) % (d + 1)) == 0)
                 && (((c - 3) / (d + 1)) < n);
            if (vl) s = trace[c-1][1:0];
            dn = (n == 0) ? (c == 1) : ((c == last_s + 1) && (a > last_s));
            if (c == 1) w = 1'b0;
            if (n > 0 && c >= 4 && (c - 1) <= last_s && (c - 1) < a && trace[c-1] == trace[2])
                w = 1'b1;
            exp_v[c] = {ld, by, vl, dn, w, s};
        end
        wrap_prev = w;
        sym_prev  = s;
    endtask

    task automatic test_reset();
        logic [6:0] v;
        reset = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.burst_len = '0; bus.decim = '0;
        mock_mode = 0; mock_seed = 22'h3ABCDE;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            reset     = (c < 3);
            bus.start = (c < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.burst_len = CNT_W'(5);
            @(negedge clk);
            v = out_vec();
            check_cnt++;
            if (v !== 7'd0) $display("FAIL reset cyc%0d got=%b exp=%b", c, v, 7'd0);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        wrap_prev = 1'b0;
        sym_prev  = 2'b00;
    endtask

    task automatic test_basic();
        mock_mode = 0; mock_seed = 22'h3ABCDE;
        drive_burst(4, 0, 0, 2, 1'b0);
        model_burst(4, 0, 0);
        for (int c = 0; c < n_cyc; c++) begin
            check_cnt++;
            if (obs[c] !== exp_v[c])
                $display("FAIL basic cyc%0d got=%b exp=%b (load,busy,valid,done,wrap,sym)", c, obs[c], exp_v[c]);
            else pass_cnt++;
        end
        check_cnt++;
        if (obs[3][1:0] !== 2'b10) $display("FAIL basic_first_sym got=%b exp=10", obs[3][1:0]);
        else pass_cnt++;
    endtask

    task automatic test_decim();
        mock_mode = 0; mock_seed = 22'($urandom);
        drive_burst(3, 2, 0, 2, 1'b1);
        model_burst(3, 2, 0);
        for (int c = 0; c < n_cyc; c++) begin
            check_cnt++;
            if (obs[c] !== exp_v[c])
                $display("FAIL decim cyc%0d got=%b exp=%b", c, obs[c], exp_v[c]);
            else pass_cnt++;
        end
    endtask

    task automatic test_zero_len();
        drive_burst(0, 3, 0, 3, 1'b0);
        model_burst(0, 3, 0);
        for (int c = 0; c < n_cyc; c++) begin
            check_cnt++;
            if (obs[c] !== exp_v[c])
                $display("FAIL zero_len cyc%0d got=%b exp=%b", c, obs[c], exp_v[c]);
            else pass_cnt++;
        end
    endtask

    task automatic test_abort();
        mock_mode = 0; mock_seed = 22'($urandom);
        drive_burst(10, 0, 3, 4, 1'b0);
        model_burst(10, 0, 3);
        for (int c = 0; c < n_cyc; c++) begin
            check_cnt++;
            if (obs[c] !== exp_v[c])
                $display("FAIL abort cyc%0d got=%b exp=%b", c, obs[c], exp_v[c]);
            else pass_cnt++;
        end
        drive_burst(5, 1, 0, 2, 1'b0);
        model_burst(5, 1, 0);
        for (int c = 0; c < n_cyc; c++) begin
            check_cnt++;
            if (obs[c] !== exp_v[c])
                $display("FAIL after_abort cyc%0d got=%b exp=%b", c, obs[c], exp_v[c]);
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        mock_mode = 1; mock_seed = 22'($urandom);
        drive_burst(8, 0, 0, 2, 1'b0);
        model_burst(8, 0, 0);
        for (int c = 0; c < n_cyc; c++) begin
            check_cnt++;
            if (obs[c] !== exp_v[c])
                $display("FAIL wrap cyc%0d got=%b exp=%b", c, obs[c], exp_v[c]);
            else pass_cnt++;
        end
        check_cnt++;
        if (obs[6][2] !== 1'b0 || obs[8][2] !== 1'b1 || obs[10][3:2] !== 2'b11)
            $display("FAIL wrap_timing got c6=%b c8=%b c10(done,wrap)=%b exp 0 1 11",
                     obs[6][2], obs[8][2], obs[10][3:2]);
        else pass_cnt++;
        mock_mode = 0;
        drive_burst(3, 0, 0, 1, 1'b0);
        model_burst(3, 0, 0);
        for (int c = 0; c < n_cyc; c++) begin
            check_cnt++;
            if (obs[c] !== exp_v[c])
                $display("FAIL wrap_clear cyc%0d got=%b exp=%b", c, obs[c], exp_v[c]);
            else pass_cnt++;
        end
    endtask

    task automatic test_start_abort_idle();
        logic [6:0] v;
        for (int c = 0; c < 4; c++) begin
            bus.start = (c == 0);
            bus.abort = (c == 0);
            bus.burst_len = CNT_W'(6);
            @(negedge clk);
            v = out_vec();
            if (c > 0) begin
                check_cnt++;
                if (v !== {4'b0000, wrap_prev, sym_prev})
                    $display("FAIL start_abort cyc%0d got=%b exp=%b", c, v, {4'b0000, wrap_prev, sym_prev});
                else pass_cnt++;
            end
            @(posedge clk); #1;
        end
        bus.abort = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [6:0] v;
        mock_mode = 0;
        for (int c = 0; c < 10; c++) begin
            bus.start = (c <= 6);
            reset     = (c == 6);
            bus.burst_len = CNT_W'(20);
            bus.decim     = DEC_W'(1);
            @(negedge clk);
            v = out_vec();
            if (c >= 1 && c <= 6) begin
                check_cnt++;
                if (v[6:5] !== {(c == 1), 1'b1})
                    $display("FAIL busy_start cyc%0d got(load,busy)=%b exp=%b", c, v[6:5], {(c == 1), 1'b1});
                else pass_cnt++;
            end
            if (c >= 7) begin
                check_cnt++;
                if (v !== 7'd0) $display("FAIL reset_mid_run cyc%0d got=%b exp=%b", c, v, 7'd0);
                else pass_cnt++;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        reset     = 1'b0;
        wrap_prev = 1'b0;
        sym_prev  = 2'b00;
    endtask

    task automatic test_back_to_back();
        int n, d;
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 6);
            d = $urandom_range(0, 3);
            mock_seed = 22'($urandom);
            drive_burst(n, d, 0, (r == 2) ? 1 : 0, 1'b1);
            model_burst(n, d, 0);
            for (int c = 0; c < n_cyc; c++) begin
                check_cnt++;
                if (obs[c] !== exp_v[c])
                    $display("FAIL back_to_back r%0d cyc%0d got=%b exp=%b", r, c, obs[c], exp_v[c]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_random();
        int n, d, a, last_s;
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(1, 12);
            d = $urandom_range(0, 5);
            last_s = 2 + (n - 1) * (d + 1);
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(1, last_s) : 0;
            mock_mode = ($urandom_range(0, 2) == 0) ? 1 : 0;
            mock_seed = 22'($urandom);
            drive_burst(n, d, a, $urandom_range(0, 2), 1'b1);
            model_burst(n, d, a);
            for (int c = 0; c < n_cyc; c++) begin
                check_cnt++;
                if (obs[c] !== exp_v[c])
                    $display("FAIL random r%0d n%0d d%0d a%0d cyc%0d got=%b exp=%b",
                             r, n, d, a, c, obs[c], exp_v[c]);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_decim();
        test_abort();
        test_wrap();
        test_start_abort_idle();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
